// File: rtl/sevenseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with per-digit mask, decimal points and PWM brightness.
// Host configuration lands in a shadow copy and becomes active only at a frame wrap.
module sevenseg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned PRESCALE   = 97,
  parameter int unsigned PWM_BITS   = 4,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_wr_valid,
  output logic                    o_wr_ready,
  input  logic [4*NUM_DIGITS-1:0] i_wr_data,
  input  logic [NUM_DIGITS-1:0]   i_wr_dp,
  input  logic [NUM_DIGITS-1:0]   i_wr_en_mask,
  input  logic [PWM_BITS-1:0]     i_wr_bright,
  output logic [NUM_DIGITS-1:0]   o_an,
  output logic [6:0]              o_seg,
  output logic                    o_dp,
  output logic                    o_frame_done
);

  localparam int unsigned DigW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0]     PreMax  = PreW'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] TickMax = '1;
  localparam logic [DigW-1:0]     DigMax  = DigW'(NUM_DIGITS - 1);

  logic [PreW-1:0]         pre_q, pre_d;
  logic [PWM_BITS-1:0]     tick_q, tick_d;
  logic [DigW-1:0]         dig_q, dig_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, shd_data_q;
  logic [NUM_DIGITS-1:0]   act_dp_q, shd_dp_q;
  logic [NUM_DIGITS-1:0]   act_mask_q, shd_mask_q;
  logic [PWM_BITS-1:0]     act_bright_q, shd_bright_q;
  logic                    pending_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q;

  logic                    pre_wrap, tick_wrap, wrap, accept, apply, lit;
  logic [3:0]              nibble;
  logic                    mask_bit, dp_bit;
  logic [NUM_DIGITS-1:0]   onehot;

  function automatic logic [6:0] hexdec(input logic [3:0] h);
    case (h)
      4'h0: hexdec = 7'h7E;
      4'h1: hexdec = 7'h30;
      4'h2: hexdec = 7'h6D;
      4'h3: hexdec = 7'h79;
      4'h4: hexdec = 7'h33;
      4'h5: hexdec = 7'h5B;
      4'h6: hexdec = 7'h5F;
      4'h7: hexdec = 7'h70;
      4'h8: hexdec = 7'h7F;
      4'h9: hexdec = 7'h7B;
      4'hA: hexdec = 7'h77;
      4'hB: hexdec = 7'h1F;
      4'hC: hexdec = 7'h4E;
      4'hD: hexdec = 7'h3D;
      4'hE: hexdec = 7'h4F;
      default: hexdec = 7'h47;
    endcase
  endfunction

  always_comb begin
    pre_wrap  = (pre_q == PreMax);
    tick_wrap = (tick_q == TickMax);
    wrap      = pre_wrap && tick_wrap && (dig_q == DigMax);
    accept    = i_wr_valid && !pending_q;
    apply     = wrap && pending_q;

    pre_d  = pre_wrap ? '0 : pre_q + 1'b1;
    tick_d = pre_wrap ? tick_q + 1'b1 : tick_q;
    dig_d  = dig_q;
    if (pre_wrap && tick_wrap) begin
      dig_d = (dig_q == DigMax) ? '0 : dig_q + 1'b1;
    end

    nibble   = '0;
    mask_bit = 1'b0;
    dp_bit   = 1'b0;
    onehot   = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_q == DigW'(k)) begin
        nibble    = act_data_q[4*k +: 4];
        mask_bit  = act_mask_q[k];
        dp_bit    = act_dp_q[k];
        onehot[k] = 1'b1;
      end
    end

    // The final tick of each slot can never satisfy tick < bright, giving a dark guard band.
    lit  = mask_bit && (tick_q < act_bright_q);
    an_d = {NUM_DIGITS{ACTIVE_LOW}} ^ (lit ? onehot : '0);
    seg_d = {7{ACTIVE_LOW}} ^ (lit ? hexdec(nibble) : 7'h00);
    dp_d  = ACTIVE_LOW ^ (lit && dp_bit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q        <= '0;
      tick_q       <= '0;
      dig_q        <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_mask_q   <= '0;
      act_bright_q <= '0;
      shd_data_q   <= '0;
      shd_dp_q     <= '0;
      shd_mask_q   <= '0;
      shd_bright_q <= '0;
      pending_q    <= 1'b0;
      an_q         <= {NUM_DIGITS{ACTIVE_LOW}};
      seg_q        <= {7{ACTIVE_LOW}};
      dp_q         <= ACTIVE_LOW;
      frame_done_q <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      tick_q       <= tick_d;
      dig_q        <= dig_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= wrap;
      if (apply) begin
        act_data_q   <= shd_data_q;
        act_dp_q     <= shd_dp_q;
        act_mask_q   <= shd_mask_q;
        act_bright_q <= shd_bright_q;
      end
      // A write accepted in the wrap cycle only fills the shadow; it waits for the next wrap.
      if (accept) begin
        shd_data_q   <= i_wr_data;
        shd_dp_q     <= i_wr_dp;
        shd_mask_q   <= i_wr_en_mask;
        shd_bright_q <= i_wr_bright;
        pending_q    <= 1'b1;
      end else if (apply) begin
        pending_q    <= 1'b0;
      end
    end
  end

  assign o_wr_ready   = !pending_q;
  assign o_an         = an_q;
  assign o_seg        = seg_q;
  assign o_dp         = dp_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed bench for sevenseg_scan_ctrl: 4 digits, 32-cycle frames, active-low outputs.
// Each frame's displayed outputs are captured per scan position and compared to hand values.
module tb_sevenseg_scan_ctrl;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic [3:0]  wr_mask;
  logic [1:0]  wr_bright;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [3:0] an_s  [32];
  logic [6:0] seg_s [32];
  logic       dp_s  [32];
  logic       rdy_s [32];
  logic       fd_s  [32];

  sevenseg_scan_ctrl #(
    .NUM_DIGITS(N),
    .PRESCALE  (2),
    .PWM_BITS  (2),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_data   (wr_data),
    .i_wr_dp     (wr_dp),
    .i_wr_en_mask(wr_mask),
    .i_wr_bright (wr_bright),
    .o_an        (an),
    .o_seg       (seg),
    .o_dp        (dp),
    .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_cfg(input logic [15:0] d, input logic [3:0] m, input logic [3:0] p,
                         input logic [1:0] b);
    wr_data   = d;
    wr_mask   = m;
    wr_dp     = p;
    wr_bright = b;
  endtask

  // Starts at a frame's first cycle; sample j shows scan position j (one-cycle output latency).
  task automatic run_frame(input int wr_j, input bit hold);
    for (int j = 0; j < 32; j++) begin
      wr_valid = hold || (j == wr_j);
      tick();
      an_s[j]  = an;
      seg_s[j] = seg;
      dp_s[j]  = dp;
      rdy_s[j] = wr_ready;
      fd_s[j]  = frame_done;
    end
    wr_valid = 1'b0;
  endtask

  function automatic int lit_cnt();
    int c = 0;
    for (int j = 0; j < 32; j++) if (an_s[j] != 4'hF) c++;
    return c;
  endfunction

  function automatic int dp_cnt();
    int c = 0;
    for (int j = 0; j < 32; j++) if (dp_s[j] == 1'b0) c++;
    return c;
  endfunction

  function automatic int rdy_cnt();
    int c = 0;
    for (int j = 0; j < 32; j++) if (rdy_s[j]) c++;
    return c;
  endfunction

  function automatic int fd_cnt();
    int c = 0;
    for (int j = 0; j < 32; j++) if (fd_s[j]) c++;
    return c;
  endfunction

  task automatic check_idle(input string tag);
    check_eq({tag, "_an"},    32'(an), 32'hF);
    check_eq({tag, "_seg"},   32'(seg), 32'h7F);
    check_eq({tag, "_dp"},    32'(dp), 32'h1);
    check_eq({tag, "_ready"}, 32'(wr_ready), 32'h1);
    check_eq({tag, "_fd"},    32'(frame_done), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    set_cfg(16'h0, 4'h0, 4'h0, 2'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
    check_idle("por");

    // R0: write A at frame start; display still blank
    set_cfg(16'h4321, 4'hF, 4'h0, 2'd3);
    run_frame(0, 1'b0);
    check_eq("r0_lit", 32'(lit_cnt()), 32'd0);
    check_eq("r0_rdy0", 32'(rdy_s[0]), 32'd0);
    check_eq("r0_rdy30", 32'(rdy_s[30]), 32'd0);
    check_eq("r0_rdy31", 32'(rdy_s[31]), 32'd1);
    check_eq("r0_fd31", 32'(fd_s[31]), 32'd1);
    check_eq("r0_fdcnt", 32'(fd_cnt()), 32'd1);

    // R1: display A (bright 3); write B (bright 1)
    set_cfg(16'h4321, 4'hF, 4'h0, 2'd1);
    run_frame(0, 1'b0);
    check_eq("a_lit", 32'(lit_cnt()), 32'd24);
    check_eq("a_an0", 32'(an_s[0]), 32'hE);
    check_eq("a_seg0", 32'(seg_s[0]), 32'h4F);
    check_eq("a_dp0", 32'(dp_s[0]), 32'h1);
    check_eq("a_an5", 32'(an_s[5]), 32'hE);
    check_eq("a_an6", 32'(an_s[6]), 32'hF);
    check_eq("a_seg6", 32'(seg_s[6]), 32'h7F);
    check_eq("a_an7", 32'(an_s[7]), 32'hF);
    check_eq("a_an8", 32'(an_s[8]), 32'hD);
    check_eq("a_seg8", 32'(seg_s[8]), 32'h12);
    check_eq("a_an16", 32'(an_s[16]), 32'hB);
    check_eq("a_seg16", 32'(seg_s[16]), 32'h06);
    check_eq("a_an24", 32'(an_s[24]), 32'h7);
    check_eq("a_seg24", 32'(seg_s[24]), 32'h4C);
    check_eq("a_dpcnt", 32'(dp_cnt()), 32'd0);

    // R2: display B; write C (bright 0)
    set_cfg(16'h4321, 4'hF, 4'h0, 2'd0);
    run_frame(0, 1'b0);
    check_eq("b_lit", 32'(lit_cnt()), 32'd8);
    check_eq("b_an1", 32'(an_s[1]), 32'hE);
    check_eq("b_an2", 32'(an_s[2]), 32'hF);
    check_eq("b_an9", 32'(an_s[9]), 32'hD);

    // R3: display C (dark); write D (mask 0101, dp on digit 2)
    set_cfg(16'h4321, 4'b0101, 4'b0100, 2'd3);
    run_frame(0, 1'b0);
    check_eq("c_lit", 32'(lit_cnt()), 32'd0);

    // R4: display D; write E exactly in the wrap cycle
    set_cfg(16'h89AB, 4'hF, 4'hF, 2'd2);
    run_frame(31, 1'b0);
    check_eq("d_lit", 32'(lit_cnt()), 32'd12);
    check_eq("d_an8", 32'(an_s[8]), 32'hF);
    check_eq("d_an16", 32'(an_s[16]), 32'hB);
    check_eq("d_dp16", 32'(dp_s[16]), 32'h0);
    check_eq("d_dp0", 32'(dp_s[0]), 32'h1);
    check_eq("d_an24", 32'(an_s[24]), 32'hF);
    check_eq("d_dpcnt", 32'(dp_cnt()), 32'd6);
    check_eq("d_rdy30", 32'(rdy_s[30]), 32'd1);
    check_eq("d_rdy31", 32'(rdy_s[31]), 32'd0);

    // R5: wrap-cycle write must not show yet
    run_frame(-1, 1'b0);
    check_eq("d2_lit", 32'(lit_cnt()), 32'd12);
    check_eq("d2_dpcnt", 32'(dp_cnt()), 32'd6);
    check_eq("d2_rdy0", 32'(rdy_s[0]), 32'd0);
    check_eq("d2_rdy30", 32'(rdy_s[30]), 32'd0);
    check_eq("d2_rdy31", 32'(rdy_s[31]), 32'd1);

    // R6: display E; valid held high with F
    set_cfg(16'h0000, 4'b0001, 4'h0, 2'd3);
    run_frame(0, 1'b1);
    check_eq("e_lit", 32'(lit_cnt()), 32'd16);
    check_eq("e_seg0", 32'(seg_s[0]), 32'h60);
    check_eq("e_seg8", 32'(seg_s[8]), 32'h08);
    check_eq("e_seg16", 32'(seg_s[16]), 32'h04);
    check_eq("e_seg24", 32'(seg_s[24]), 32'h00);
    check_eq("e_dp0", 32'(dp_s[0]), 32'h0);
    check_eq("e_dp2", 32'(dp_s[2]), 32'h0);
    check_eq("e_dp4", 32'(dp_s[4]), 32'h1);
    check_eq("e_rdycnt", 32'(rdy_cnt()), 32'd1);
    check_eq("e_fdcnt", 32'(fd_cnt()), 32'd1);

    // R7: display F; valid still held
    run_frame(0, 1'b1);
    check_eq("f_lit", 32'(lit_cnt()), 32'd6);
    check_eq("f_an0", 32'(an_s[0]), 32'hE);
    check_eq("f_seg0", 32'(seg_s[0]), 32'h01);
    check_eq("f_rdycnt", 32'(rdy_cnt()), 32'd1);
    check_eq("f_fd31", 32'(fd_s[31]), 32'd1);

    // Reset mid-frame with a write pending
    set_cfg(16'hFFFF, 4'hF, 4'hF, 2'd3);
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check_eq("pend_ready", 32'(wr_ready), 32'd0);
    repeat (4) tick();
    check_eq("pre_rst_an", 32'(an), 32'hE);
    rst = 1'b1;
    repeat (3) tick();
    check_idle("rst");
    rst = 1'b0;
    cyc = 0;
    run_frame(-1, 1'b0);
    check_eq("post_lit", 32'(lit_cnt()), 32'd0);
    check_eq("post_rdycnt", 32'(rdy_cnt()), 32'd32);
    check_eq("post_fd31", 32'(fd_s[31]), 32'd1);
    check_eq("post_fdcnt", 32'(fd_cnt()), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
